// File: rtl/mm_modexp_ctrl_pkg.sv
// Shared types and constants for the Montgomery modular-exponentiation controller
// and its radix-2 Montgomery multiplier.
package mm_modexp_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TO_MONT,
        ONE_MONT,
        SQR,
        MUL,
        FROM_MONT
    } exp_state_e;

    typedef enum logic {
        ISSUE,
        WAIT
    } mm_phase_e;

    typedef enum logic [1:0] {
        MM_IDLE,
        MM_RUN,
        MM_SUB
    } mm_core_state_e;

    // Fixed multiplications: entry into the domain for x, for 1, and exit.
    localparam int unsigned MM_FIXED_OPS = 3;

    function automatic int unsigned mm_op_count(input int unsigned e_w, input int unsigned ones);
        return MM_FIXED_OPS + e_w + ones;
    endfunction

endpackage

// File: rtl/mm_modexp_ctrl_r2mm.sv
// Bit-serial radix-2 Montgomery multiplier: z = x*y*2^-K mod m, one operand bit per cycle,
// one closing conditional subtraction, one-cycle valid pulse with z held afterwards.
module mm_r2mm_2n
    import mm_modexp_ctrl_pkg::*;
#(
    parameter int K = 2048
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_i,
    input  logic [K-1:0] x_i,
    input  logic [K-1:0] y_i,
    input  logic [K-1:0] m_i,
    output logic         valid_o,
    output logic [K-1:0] z_o
);

    localparam int CW = $clog2(K);

    mm_core_state_e state_q, state_d;
    logic [K-1:0]   x_q, x_d;
    logic [K-1:0]   y_q, y_d;
    logic [K-1:0]   m_q, m_d;
    logic [K+1:0]   s_q, s_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           valid_q, valid_d;
    logic [K-1:0]   z_q, z_d;

    // Partial sum stays below 2m; adding y and m keeps it below 4m, so K+2 bits suffice.
    logic [K+1:0]   sum_xy;
    logic [K+1:0]   sum_q;

    always_comb begin
        sum_xy = s_q + (x_q[0] ? {2'b00, y_q} : '0);
        sum_q  = sum_xy + (sum_xy[0] ? {2'b00, m_q} : '0);
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        m_d     = m_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        z_d     = z_q;
        unique case (state_q)
            MM_IDLE: begin
                if (req_i) begin
                    x_d     = x_i;
                    y_d     = y_i;
                    m_d     = m_i;
                    s_d     = '0;
                    cnt_d   = '0;
                    state_d = MM_RUN;
                end
            end
            MM_RUN: begin
                s_d = sum_q >> 1;
                x_d = x_q >> 1;
                if (cnt_q == CW'(K - 1)) begin
                    state_d = MM_SUB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MM_SUB: begin
                z_d     = (s_q >= {2'b00, m_q}) ? K'(s_q - {2'b00, m_q}) : K'(s_q);
                valid_d = 1'b1;
                state_d = MM_IDLE;
            end
            default: state_d = MM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MM_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            m_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            m_q     <= m_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            z_q     <= z_d;
        end
    end

    assign valid_o = valid_q;
    assign z_o     = z_q;

endmodule

// File: rtl/mm_modexp_ctrl.sv
// Left-to-right square-and-multiply modular exponentiation in the Montgomery domain,
// sequencing a single shared Montgomery multiplier.
module mm_modexp_ctrl
    import mm_modexp_ctrl_pkg::*;
#(
    parameter int K   = 2048,
    parameter int E_W = 2048
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [K-1:0]   base,
    input  logic [E_W-1:0] exp,
    input  logic [K-1:0]   mod,
    input  logic [K-1:0]   r2,
    output logic           busy,
    output logic           done,
    output logic [K-1:0]   result
);

    localparam int IW = (E_W > 1) ? $clog2(E_W) : 1;
    localparam logic [K-1:0] ONE = K'(1);

    // Handshake with the multiplier: mm_req is a single-cycle pulse issued in ISSUE;
    // operands are latched by the multiplier on that edge and the result is taken
    // only on the cycle mm_valid is high, never by counting cycles.
    exp_state_e     state_q, state_d;
    mm_phase_e      phase_q, phase_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [K-1:0]   result_q, result_d;
    logic [K-1:0]   base_q, base_d;
    logic [E_W-1:0] exp_q, exp_d;
    logic [K-1:0]   mod_q, mod_d;
    logic [K-1:0]   r2_q, r2_d;
    logic [K-1:0]   xm_q, xm_d;
    logic [K-1:0]   acc_q, acc_d;
    logic [IW-1:0]  idx_q, idx_d;

    logic           mm_req;
    logic [K-1:0]   mm_x;
    logic [K-1:0]   mm_y;
    logic           mm_valid;
    logic [K-1:0]   mm_z;

    assign mm_req = (state_q != IDLE) && (phase_q == ISSUE);

    always_comb begin
        mm_x = acc_q;
        mm_y = acc_q;
        unique case (state_q)
            TO_MONT:   begin mm_x = base_q; mm_y = r2_q;  end
            ONE_MONT:  begin mm_x = ONE;    mm_y = r2_q;  end
            SQR:       begin mm_x = acc_q;  mm_y = acc_q; end
            MUL:       begin mm_x = acc_q;  mm_y = xm_q;  end
            FROM_MONT: begin mm_x = acc_q;  mm_y = ONE;   end
            default:   begin mm_x = acc_q;  mm_y = acc_q; end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        base_d   = base_q;
        exp_d    = exp_q;
        mod_d    = mod_q;
        r2_d     = r2_q;
        xm_d     = xm_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        if (state_q == IDLE) begin
            if (start && !busy_q) begin
                base_d  = base;
                exp_d   = exp;
                mod_d   = mod;
                r2_d    = r2;
                busy_d  = 1'b1;
                phase_d = ISSUE;
                state_d = TO_MONT;
            end
        end else if (phase_q == ISSUE) begin
            phase_d = WAIT;
        end else if (mm_valid) begin
            phase_d = ISSUE;
            unique case (state_q)
                TO_MONT: begin
                    xm_d    = mm_z;
                    state_d = ONE_MONT;
                end
                ONE_MONT: begin
                    acc_d   = mm_z;
                    idx_d   = IW'(E_W - 1);
                    state_d = SQR;
                end
                SQR: begin
                    acc_d = mm_z;
                    if (exp_q[idx_q]) begin
                        state_d = MUL;
                    end else if (idx_q == '0) begin
                        state_d = FROM_MONT;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
                MUL: begin
                    acc_d = mm_z;
                    if (idx_q == '0) begin
                        state_d = FROM_MONT;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = SQR;
                    end
                end
                FROM_MONT: begin
                    result_d = mm_z;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            phase_q  <= ISSUE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            base_q   <= '0;
            exp_q    <= '0;
            mod_q    <= '0;
            r2_q     <= '0;
            xm_q     <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            base_q   <= base_d;
            exp_q    <= exp_d;
            mod_q    <= mod_d;
            r2_q     <= r2_d;
            xm_q     <= xm_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
        end
    end

    mm_r2mm_2n #(
        .K (K)
    ) u_mm (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (mm_req),
        .x_i     (mm_x),
        .y_i     (mm_y),
        .m_i     (mod_q),
        .valid_o (mm_valid),
        .z_o     (mm_z)
    );

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mm_modexp_ctrl.sv
// Directed scoreboard bench for mm_modexp_ctrl with K=8, E_W=8, mod=13, r2=3.
module tb_mm_modexp_ctrl;
  import mm_modexp_ctrl_pkg::*;

  localparam int K   = 8;
  localparam int E_W = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [K-1:0]   base;
  logic [E_W-1:0] exp;
  logic [K-1:0]   mod;
  logic [K-1:0]   r2;
  logic           busy;
  logic           done;
  logic [K-1:0]   result;

  logic [K-1:0] exp_q[$];
  int           cnt_q[$];
  int           checks;
  int           fails;
  int           req_cnt;
  logic         in_op;
  logic         busy_ok;

  mm_modexp_ctrl #(.K(K), .E_W(E_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .base   (base),
    .exp    (exp),
    .mod    (mod),
    .r2     (r2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      fails++;
      $display("FAIL %s: actual=%0d required=%0d", name, actual, required);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      in_op   = 1'b0;
      req_cnt = 0;
    end else begin
      if (dut.mm_req) req_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          check("result", int'(result), int'(exp_q.pop_front()));
          check("mm_requests", req_cnt, cnt_q.pop_front());
          check("busy_held", int'(busy_ok), 1);
          check("busy_low_at_done", int'(busy), 0);
        end
        in_op = 1'b0;
      end else if (in_op && !busy) begin
        busy_ok = 1'b0;
      end
      if (start && !busy) begin
        in_op   = 1'b1;
        busy_ok = 1'b1;
        req_cnt = 0;
      end
    end
  end

  // driver tasks
  task automatic pulse_start(input logic [K-1:0] b, input logic [E_W-1:0] e,
                             input bit push, input logic [K-1:0] res, input int n_req);
    @(posedge clk); #1;
    base  = b;
    exp   = e;
    start = 1'b1;
    if (push) begin
      exp_q.push_back(res);
      cnt_q.push_back(n_req);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic start_in_done_cycle(input logic [K-1:0] b, input logic [E_W-1:0] e,
                                     input logic [K-1:0] res, input int n_req);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("done_seen_before_timeout", int'(seen), 1);
    base  = b;
    exp   = e;
    start = 1'b1;
    exp_q.push_back(res);
    cnt_q.push_back(n_req);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", int'(exp_q.size()), 0);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    bit hit;
    checks  = 0;
    fails   = 0;
    req_cnt = 0;
    in_op   = 1'b0;
    busy_ok = 1'b1;
    rst_n   = 1'b0;
    start   = 1'b0;
    base    = '0;
    exp     = '0;
    mod     = 8'd13;
    r2      = 8'd3;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_result", int'(result), 0);
    rst_n = 1'b1;

    // 2^10 mod 13 = 10; e=0b1010 has two ones
    pulse_start(8'd2, 8'd10, 1'b1, 8'd10, 13);
    drain();
    pulse_start(8'd7, 8'd0, 1'b1, 8'd1, 11);
    drain();
    pulse_start(8'd0, 8'd5, 1'b1, 8'd0, 13);
    drain();
    pulse_start(8'd12, 8'd2, 1'b1, 8'd1, 12);
    drain();

    // start re-pulsed with different inputs while busy must be ignored
    pulse_start(8'd2, 8'd10, 1'b1, 8'd10, 13);
    repeat (5) @(posedge clk);
    mod = 8'd11;
    r2  = 8'd5;
    pulse_start(8'd5, 8'd7, 1'b0, 8'd0, 0);
    drain();
    mod = 8'd13;
    r2  = 8'd3;

    // reset mid-SQR aborts without done; later 3^3 mod 13 = 1
    pulse_start(8'd2, 8'd10, 1'b0, 8'd0, 0);
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(posedge clk); #1;
      if (dut.state_q == SQR) hit = 1'b1;
    end
    check("reached_sqr", int'(hit), 1);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #1;
    check("abort_result", int'(result), 0);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    pulse_start(8'd3, 8'd3, 1'b1, 8'd1, 13);
    drain();

    // back-to-back: second start lands in the first done cycle
    pulse_start(8'd2, 8'd10, 1'b1, 8'd10, 13);
    start_in_done_cycle(8'd2, 8'd10, 8'd10, 13);
    drain();

    check("scoreboard_empty", int'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
